// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: funct codes, word width and
// the multiply/divide sequencer state encoding.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_MUL   = 3'd1,
        MD_DIV   = 3'd2,
        MD_DONE  = 3'd3,
        MD_DZERO = 3'd4
    } md_state_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the main control unit (master) and the
// multiply/divide sequencer (slave).
interface mult_div_ctrl_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT/DIV sequencer owning HI/LO. Works on magnitudes with a
// shift-add / restoring shift-subtract step per cycle; signs are fixed on exit.
module mult_div_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input logic            clk,
    input logic            reset,
    mult_div_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sign_q, sign_d;
    logic               dsign_q, dsign_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic               last;

    function automatic logic [WIDTH-1:0] abs_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_step = {add_sum, acc_q[WIDTH-1:1]};
        shifted  = acc_q[2*WIDTH-1:WIDTH-1];
        sub_diff = shifted - {1'b0, opnd_q};
        // Borrow out means the divisor did not fit: restore and shift in a 0.
        div_step = sub_diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sign_d  = sign_q;
        dsign_d = dsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MD_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d      = MD_DONE;
                    {hi_d, lo_d} = sign_q ? -mul_step : mul_step;
                end
            end
            MD_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = MD_DONE;
                    lo_d    = abs_neg(div_step[WIDTH-1:0], sign_q);
                    hi_d    = abs_neg(div_step[2*WIDTH-1:WIDTH], dsign_q);
                end
            end
            default: begin
                state_d = MD_IDLE;
                if (bus.start_mult) begin
                    state_d = MD_MUL;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, abs_neg(bus.b, bus.b[WIDTH-1])};
                    opnd_d  = abs_neg(bus.a, bus.a[WIDTH-1]);
                    sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                end else if (bus.start_div) begin
                    if (bus.b == '0) begin
                        state_d = MD_DZERO;
                    end else begin
                        state_d = MD_DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, abs_neg(bus.a, bus.a[WIDTH-1])};
                        opnd_d  = abs_neg(bus.b, bus.b[WIDTH-1]);
                        sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        dsign_d = bus.a[WIDTH-1];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sign_q  <= 1'b0;
            dsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sign_q  <= sign_d;
            dsign_q <= dsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy     = (state_q == MD_MUL) || (state_q == MD_DIV);
    assign bus.done     = (state_q == MD_DONE);
    assign bus.div_zero = (state_q == MD_DZERO);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: per-cycle comparison against an
// arithmetic reference model, plus directed literal results.
module tb_mult_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_ctrl_if #(.WIDTH(W)) bus ();
    mult_div_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p;
    endfunction

    // Returns {remainder, quotient} with C-style truncation toward zero.
    function automatic logic [2*W-1:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Reference model: an operation occupies W cycles, then results land.
    int           m_left;
    logic         m_done, m_dz;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (bus.start_mult) begin
                {p_hi, p_lo} <= mul_ref(bus.a, bus.b);
                m_left       <= W;
            end else if (bus.start_div) begin
                if (bus.b == '0) begin
                    m_dz <= 1'b1;
                end else begin
                    {p_hi, p_lo} <= div_ref(bus.a, bus.b);
                    m_left       <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("busy", W'(bus.busy), W'(m_left > 0));
            chk("done", W'(bus.done), W'(m_done));
            chk("div_zero", W'(bus.div_zero), W'(m_dz));
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    task automatic start_op(input bit mul, input bit dv, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bus.start_mult = mul;
        bus.start_div  = dv;
        bus.a          = a;
        bus.b          = b;
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
    endtask

    task automatic wait_end(output int n, output int bc);
        n  = 0;
        bc = bus.busy ? 1 : 0;
        while (!(bus.done || bus.div_zero) && n < 60) begin
            @(negedge clk);
            n++;
            bc += bus.busy ? 1 : 0;
        end
        if (n >= 60) chk("completion_timeout", W'(n), W'(32));
    endtask

    task automatic do_op(input string name, input bit mul, input bit dv, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n, bc;
        start_op(mul, dv, a, b);
        wait_end(n, bc);
        chk({name, "_latency"}, W'(n), W'(32));
        chk({name, "_busy_cycles"}, W'(bc), W'(32));
        chk({name, "_hi"}, bus.hi, ehi);
        chk({name, "_lo"}, bus.lo, elo);
    endtask

    initial begin
        int n, bc, kind;
        logic [W-1:0] ra, rb;
        reset          = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", W'(bus.busy), '0);
        chk("reset_done", W'(bus.done), '0);
        chk("reset_dz", W'(bus.div_zero), '0);
        chk("reset_hi", bus.hi, '0);
        chk("reset_lo", bus.lo, '0);
        reset    = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        do_op("mul_mixed", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mul_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        do_op("mul_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        do_op("div_neg7", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_by_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        do_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Divide by zero keeps the preloaded HI/LO.
        do_op("preload", 1, 0, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0);
        start_op(0, 1, 32'd5, 32'd0);
        chk("dz_pulse", W'(bus.div_zero), W'(1));
        chk("dz_busy", W'(bus.busy), '0);
        chk("dz_done", W'(bus.done), '0);
        chk("dz_hi", bus.hi, 32'h3);
        chk("dz_lo", bus.lo, 32'h0);
        @(negedge clk);
        chk("dz_pulse_end", W'(bus.div_zero), '0);
        chk("dz_busy_after", W'(bus.busy), '0);
        chk("dz_done_after", W'(bus.done), '0);

        do_op("both_starts", 1, 1, 32'd6, 32'd3, 32'h0, 32'd18);

        // A start arriving mid-operation is ignored.
        start_op(1, 0, 32'd2, 32'd3);
        repeat (10) @(negedge clk);
        start_op(0, 1, 32'd100, 32'd7);
        wait_end(n, bc);
        chk("ignored_start_latency", W'(n), W'(21));
        chk("ignored_start_lo", bus.lo, 32'd6);

        // Start during the DONE cycle is accepted without a gap.
        start_op(1, 0, 32'd5, 32'd6);
        wait_end(n, bc);
        chk("b2b_first_lo", bus.lo, 32'd30);
        start_op(0, 1, 32'd100, 32'd7);
        wait_end(n, bc);
        chk("b2b_latency", W'(n), W'(32));
        chk("b2b_hi", bus.hi, 32'd2);
        chk("b2b_lo", bus.lo, 32'd14);

        // Asynchronous reset between edges in the middle of a divide.
        start_op(0, 1, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        checking = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", W'(bus.busy), '0);
        chk("areset_done", W'(bus.done), '0);
        chk("areset_hi", bus.hi, '0);
        chk("areset_lo", bus.lo, '0);
        @(negedge clk);
        reset    = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        do_op("post_reset", 1, 0, 32'd3, 32'd4, 32'h0, 32'd12);

        // Random traffic checked cycle by cycle against the model.
        repeat (40) begin
            kind = int'($urandom_range(0, 2));
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = W'($urandom_range(1, 9));
                default: ;
            endcase
            start_op(kind != 1, kind != 0, ra, rb);
            wait_end(n, bc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

- Iterative signed multiply/divide sequencer for the multicycle MIPS core.
- Serves the MULT and DIV instructions and owns the HI/LO registers read by MFHI/MFLO.
- The main control unit pulses a start, waits on `busy`/`done`, and branches to its divide-by-zero exception state on `div_zero`.
- Contains the FSM, the iteration counter and the shift/add-subtract registers.

## Interface

- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`, in, 1: clock. All registers update on the rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-high.
- `start_mult`, in, 1: request a signed multiply of `a`×`b`. Sampled only when accepting.
- `start_div`, in, 1: request a signed divide of `a`÷`b`. Sampled only when accepting.
- `a`, in, `WIDTH`: rs operand. Captured on the accepting edge.
- `b`, in, `WIDTH`: rt operand. Captured on the accepting edge.
- `busy`, out, 1: iteration in progress.
- `done`, out, 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `div_zero`, out, 1: one-cycle pulse; divisor was zero.
- `hi`, out, `WIDTH`: HI register. Holds its value between operations.
- `lo`, out, `WIDTH`: LO register. Holds its value between operations.

## Operation

- **States:** IDLE, MUL, DIV, DONE, DZERO. Reset enters IDLE, and `hi`, `lo`, the counter and all outputs become 0.
- **Accepting states:** IDLE, DONE and DZERO. On an edge in any of these:
  - `start_mult` → MUL. Capture |a|, |b| and the result sign a[W-1]^b[W-1]. Counter = 0.
  - `start_div` with b≠0 → DIV. Capture |a|, |b|, the quotient sign and the dividend sign. Counter = 0.
  - `start_div` with b=0 → DZERO. `hi`/`lo` are unchanged.
  - Both starts asserted → multiply; `start_div` is ignored.
  - No start → IDLE.
- **MUL:** one shift-add step per cycle on a 2·WIDTH-bit product register, unsigned, on magnitudes. Counter increments each cycle. After the step with counter = WIDTH-1 → DONE, writing `{hi,lo}` = product, negated if the sign is 1.
- **DIV:** one restoring shift-subtract step per cycle, unsigned, on magnitudes. After WIDTH steps → DONE, writing:
  - `lo` = quotient, negated if the quotient sign is 1 (truncation toward zero).
  - `hi` = remainder, negated if the dividend sign is 1.
- **Width rules:** abs and negate use two's-complement wraparound at `WIDTH` bits. |0x80000000| = 0x80000000, treated as unsigned 2^31, which is correct. Therefore:
  - 0x80000000 ÷ 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0, with no flag.
- **Outputs:**
  - `busy` = state ∈ {MUL, DIV}.
  - `done` = state is DONE.
  - `div_zero` = state is DZERO.
  - All three are Moore outputs, registered through the state.
- **Starts while busy** are ignored; the operation in flight completes unaffected.
- **Operand changes** after the accepting edge have no effect.
- **Reset mid-operation:** aborts immediately. Results are discarded and `hi`/`lo` = 0.

## Timing

- Accepting edge E0; iteration edges E1…E(WIDTH).
- MUL/DIV: `busy` is high from after E0 until edge E(WIDTH). `hi`/`lo` update at E(WIDTH). `done` is high for the single cycle after E(WIDTH).
  - Latency: WIDTH edges, i.e. 32 cycles for WIDTH=32.
- Back-to-back: a start sampled during the DONE cycle is accepted. There is no dead cycle between operations.
- DZERO: `div_zero` is high for the cycle after E0. `busy` is never asserted. The FSM returns to IDLE (or accepts a new start) at the next edge.
- `hi`/`lo` change only on the completion edge or on reset. They never show partial values.

## Structure

- Shared package `mips_pkg` holds:
  - the state encoding constants (`MD_IDLE`, `MD_MUL`, `MD_DIV`, `MD_DONE`, `MD_DZERO`);
  - the `WORD_W` = 32 constant used as the default `WIDTH`.
- The funct codes for MULT/DIV/MFHI/MFLO also move into `mips_pkg`, so that the control unit and this block share them.
- No sub-module is required.
  - The FSM, counter and iteration registers live in one module.
  - An optional combinational helper `abs_neg` (magnitude and conditional negate) may be used for the entry and exit sign handling.

## Test plan

- **Multiply, mixed signs:** mult a=7, b=0xFFFFFFFD (−3) → `done` at E32 only, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high for exactly 32 cycles.
- **Multiply, extreme operands:** mult a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Then mult 0xFFFFFFFF×0xFFFFFFFF → `hi`=0, `lo`=1.
- **Divide, signed truncation:**
  - div a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - div 7÷0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
  - div 0x80000000÷0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload `hi`/`lo` from a prior multiply, then div 5÷0 → `div_zero` pulse in the cycle after start, `busy`=0 throughout, `hi`/`lo` unchanged, `done` never asserted.
- **Arbitration:**
  - `start_mult` and `start_div` together → multiply result.
  - A start pulsed at iteration 10 → ignored.
  - A start during the DONE cycle → accepted, with the next `done` 32 cycles later.
- **Reset mid-operation:** assert `reset` asynchronously, between edges, at iteration 10 of a divide → `busy`, `done`, `hi` and `lo` go to 0 immediately. After release, mult 3×4 → `lo`=12, `hi`=0.
